shift_unit: RTL and testbench
=============================

# shift_unit

Multi-cycle, parametrised shift unit for the MIPS datapath. It supersedes the single-mode combinational left shifter with four modes: logical left, logical right, arithmetic right and rotate right. It runs at a configurable number of bit positions per cycle behind valid/ready handshakes. The EX stage uses it for SLL/SRL/SRA/ROTR (and the variable forms), trading latency for a smaller shifter.

## Interface

Parameters:
- WIDTH, 32, operand/result width; power of two, ≥ 2.
- STEP, 4, maximum bit positions shifted per cycle; power of two, 1..WIDTH.
- SHW (localparam), $clog2(WIDTH), shift-amount width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request (high only in IDLE).
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount, 0..WIDTH-1.
- out_valid  output  1  result available (high only in DONE).
- out_ready  input  1  consumer takes result.
- out_data  output  WIDTH  shifted result.

## Operation

- FSM states are IDLE, SHIFT and DONE. Internal registers: acc[WIDTH], rem[SHW], op[2].
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: acc←in_data, rem←in_shamt, op←in_op, go to SHIFT.
- SHIFT, one step per cycle:
  - amt = (rem < STEP) ? rem : STEP.
  - acc←acc shifted by amt per op:
    - SLL fills zeros at the LSB.
    - SRL fills zeros at the MSB.
    - SRA replicates acc[WIDTH-1] (the original sign, which stays invariant across steps).
    - ROR moves the bits shifted out of the LSB end into the MSB end.
  - rem←rem−amt.
  - If rem ≤ STEP (this includes rem=0), go to DONE after this step; otherwise stay in SHIFT.
  - rem=0 on entry means no shift and a direct move to DONE.
- DONE:
  - out_valid=1, out_data=acc, held stable while out_ready=0.
  - On out_ready: go to IDLE.
  - No same-cycle accept; in_ready rises the cycle after the handoff.
- Inputs are ignored whenever in_ready=0. A request presented during SHIFT/DONE is not captured, and the requester must hold it.
- in_op/in_data/in_shamt are sampled only on the accept edge; later changes do not affect the operation in flight.
- out_data is driven from acc in every state. It is meaningful only while out_valid=1.
- in_shamt ≥ WIDTH is unrepresentable by construction (SHW bits).

## Timing

- Reset values: state=IDLE, acc=0, rem=0, op=00. Hence in_ready=1, out_valid=0, out_data=0 from the first cycle after reset deasserts.
- rst asserted in any state (including mid-SHIFT or DONE with out_ready=0) aborts the operation on that edge with no output produced. rst has priority over all handshakes.
- Let the accept edge be E0. Let N = max(1, ceil(shamt/STEP)).
  - SHIFT occupies the N cycles after E0.
  - out_valid is high after edge EN.
  - Examples at WIDTH=32, STEP=4: shamt=31 gives N=8; shamt=0 gives N=1; shamt=4 gives N=1; shamt=5 gives N=2.
  - With STEP=WIDTH, every request has N=1.
- Minimum request-to-request period is N+2 cycles: accept, N shift cycles, DONE with out_ready=1, then IDLE.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready.

## Test plan

- Reset, then idle: assert rst for 2 cycles. After release, expect in_ready=1, out_valid=0, out_data=0x00000000.
- SLL full range (WIDTH=32, STEP=4): send in_data=0x00000001, shamt=31, op=00 at E0. Expect out_valid first high after E8 with out_data=0x80000000. Expect in_ready low from E1 through the handoff.
- SRA and SRL sign behaviour:
  - 0x80000000 with shamt=4, op=10 gives 0xF8000000 after E1.
  - The same operand with op=01, shamt=5 gives 0x04000000 after E2.
- ROR and zero shift:
  - 0x12345678 with shamt=8, op=11 gives 0x78123456 after E2.
  - shamt=0 with any op returns in_data unchanged after E1.
- Backpressure and ignored inputs:
  - Hold out_ready=0 for 5 cycles in DONE. out_valid and out_data must stay stable.
  - Toggle in_valid with new data during SHIFT/DONE. The result is unchanged and no second request is captured until in_ready=1 again.
- Reset mid-operation: start SLL shamt=31, then assert rst at the cycle-3 edge. The next cycle shows IDLE with out_data=0 and in_ready=1. A subsequent 0x0000000F, shamt=4, SLL yields 0x000000F0.

Source files
------------

// File: rtl/shift_unit.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROR) that moves up to STEP bit positions per cycle.
// Requests are accepted only in StIdle, and the result is held in StDone until it is consumed.
module shift_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4,
    localparam int unsigned SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
    typedef enum logic [1:0] {OpSll = 2'b00, OpSrl = 2'b01, OpSra = 2'b10, OpRor = 2'b11} op_e;

    // StepLo reads as zero when STEP == WIDTH, but that case always takes the rem_q branch.
    localparam logic [SHW:0]   StepW  = STEP[SHW:0];
    localparam logic [SHW-1:0] StepLo = STEP[SHW-1:0];

    state_e                  state_q;
    op_e                     op_q;
    logic        [WIDTH-1:0] acc_q, acc_d;
    logic        [SHW-1:0]   rem_q, rem_d;
    logic        [SHW-1:0]   amt, amt_neg;
    logic signed [WIDTH-1:0] acc_s;
    logic                    last_step;

    always_comb begin
        amt       = ({1'b0, rem_q} < StepW) ? rem_q : StepLo;
        amt_neg   = '0 - amt;
        last_step = {1'b0, rem_q} <= StepW;
        rem_d     = rem_q - amt;
        acc_s     = acc_q;
        acc_d     = acc_q;
        unique case (op_q)
            OpSll: acc_d = acc_q << amt;
            OpSrl: acc_d = acc_q >> amt;
            OpSra: acc_d = acc_s >>> amt;
            OpRor: acc_d = (acc_q >> amt) | (acc_q << amt_neg);
            default: acc_d = acc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= OpSll;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        acc_q   <= in_data;
                        rem_q   <= in_shamt;
                        op_q    <= op_e'(in_op);
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    if (last_step) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_data  = acc_q;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit at WIDTH=32, STEP=4: results are queued at request time and
// compared when the unit hands them off.
module tb_shift_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    shift_unit #(
        .WIDTH(32),
        .STEP (4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Bitwise reference, built one output bit at a time.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                          input int sh);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            case (op)
                2'b00:   r[i] = (i >= sh) ? d[i-sh] : 1'b0;
                2'b01:   r[i] = (i + sh < 32) ? d[i+sh] : 1'b0;
                2'b10:   r[i] = (i + sh < 32) ? d[i+sh] : d[31];
                default: r[i] = d[(i+sh)%32];
            endcase
        end
        return r;
    endfunction

    // Handoff monitor: a result is taken whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_result", 32'(exp_q.size()), 32'd1);
            end else begin
                check_eq("result", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic do_req(input logic [1:0] op, input logic [31:0] data, input logic [4:0] sh,
                          input logic [31:0] exp, input int hold, input bit noise);
        int          lat;
        int          n_exp;
        logic [31:0] held;
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("ready_before_req", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        in_shamt = sh;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_exp    = (sh == 0) ? 1 : (int'(sh) + 3) / 4;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            check_eq("busy_in_shift", 32'(in_ready), 32'd0);
            if (noise) begin
                in_valid = lat[0];
                in_op    = 2'($urandom);
                in_data  = $urandom;
                in_shamt = 5'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(n_exp));
        held = out_data;
        repeat (hold) begin
            if (noise) begin
                in_valid = ~in_valid;
                in_data  = $urandom;
            end
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_data", out_data, held);
            check_eq("busy_in_done", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("idle_valid", 32'(out_valid), 32'd0);
        check_eq("idle_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] d;
        logic [4:0]  sh;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = '0;
        in_shamt  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", out_data, 32'h0);

        do_req(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 0, 1'b0);
        do_req(2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 0, 1'b0);
        do_req(2'b01, 32'h8000_0000, 5'd5,  32'h0400_0000, 0, 1'b0);
        do_req(2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456, 0, 1'b0);
        do_req(2'b10, 32'hA5A5_0F0F, 5'd0,  32'hA5A5_0F0F, 0, 1'b0);
        do_req(2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0, 1'b0);
        do_req(2'b10, 32'h8765_4321, 5'd31, 32'hFFFF_FFFF, 5, 1'b1);
        do_req(2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 5, 1'b1);

        // Abort an SLL by 31 on the third edge after the accept.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_data  = 32'h0000_0001;
        in_shamt = 5'd31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_ready", 32'(in_ready), 32'd1);
        check_eq("abort_valid", 32'(out_valid), 32'd0);
        check_eq("abort_data", out_data, 32'h0);
        do_req(2'b00, 32'h0000_000F, 5'd4, 32'h0000_00F0, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom);
            d  = $urandom;
            sh = 5'($urandom);
            do_req(op, d, sh, model(op, d, int'(sh)), int'($urandom_range(0, 2)),
                   1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1 check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
